// File: rtl/ascon_enc_scheduler_pkg.sv
// Shared constants and the FSM state type for the Ascon encrypt scheduler.
// No logic: type and parameter definitions only.
// No handshake involved.
package ascon_ctrl_pkg;

  localparam int ASCON_W         = 128;
  localparam int TIMEOUT_CYC_DEF = 64;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/ascon_enc_scheduler_if.sv
// Requester/response bundle between the engines and the scheduler.
// Pure wiring, no latency.
// Requests use per-requester valid/ready, the response a single valid/ready pair.
interface ascon_enc_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
);
  import ascon_ctrl_pkg::*;

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [ASCON_W*NUM_REQ-1:0] req_sk;
  logic [ASCON_W*NUM_REQ-1:0] req_n;
  logic [ASCON_W*NUM_REQ-1:0] req_a;
  logic [ASCON_W*NUM_REQ-1:0] req_p;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [IDW-1:0]             rsp_id;
  logic [ASCON_W-1:0]         rsp_c;
  logic [ASCON_W-1:0]         rsp_t;
  logic                       rsp_err;

  modport master (
    output req_valid, req_sk, req_n, req_a, req_p, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_c, rsp_t, rsp_err
  );

  modport slave (
    input  req_valid, req_sk, req_n, req_a, req_p, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_c, rsp_t, rsp_err
  );

endinterface

// File: rtl/ascon_enc_scheduler_rr_arbiter.sv
// Rotating-priority arbiter: the requester just after last_grant wins first.
// Purely combinational, zero latency.
// No backpressure of its own; the caller gates the grant by its state.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last_grant,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     gnt_idx,
  output logic               gnt_vld
);

  logic [IDW-1:0] idx;

  // Walk from lowest to highest priority so the nearest valid requester overwrites
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IDW'((int'(last_grant) + k) % NUM_REQ);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        gnt_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ascon_enc_scheduler.sv
// Shares one Ascon-128a encrypt core among NUM_REQ requesters, round-robin, one job at a time.
// Latency: accept, 1 START cycle, 1..TIMEOUT_CYC WAIT cycles, then response.
// Backpressure: response held until rsp_ready; no request accepted until then.
module ascon_enc_scheduler
  import ascon_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int IDW         = 2,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int TW          = 7
) (
  input  logic               CLK,
  input  logic               RST,
  ascon_enc_scheduler_if.slave bus,
  output logic [ASCON_W-1:0] core_sk,
  output logic [ASCON_W-1:0] core_n,
  output logic [ASCON_W-1:0] core_a,
  output logic [ASCON_W-1:0] core_p,
  output logic               core_start,
  output logic               core_reset,
  input  logic               core_done,
  input  logic [ASCON_W-1:0] core_c,
  input  logic [ASCON_W-1:0] core_t,
  output logic               busy
);

  state_t             state;
  logic [IDW-1:0]     last_grant;
  logic [TW-1:0]      wdog;
  logic [IDW-1:0]     rsp_id_q;
  logic [ASCON_W-1:0] rsp_c_q;
  logic [ASCON_W-1:0] rsp_t_q;
  logic               rsp_err_q;
  logic               rsp_valid_q;
  logic               core_start_q;

  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     gnt_idx;
  logic               gnt_vld;
  logic               accept;
  logic               timeout_hit;

  logic [ASCON_W-1:0] sk_arr [NUM_REQ];
  logic [ASCON_W-1:0] n_arr  [NUM_REQ];
  logic [ASCON_W-1:0] a_arr  [NUM_REQ];
  logic [ASCON_W-1:0] p_arr  [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign sk_arr[i] = bus.req_sk[ASCON_W*i +: ASCON_W];
    assign n_arr[i]  = bus.req_n[ASCON_W*i +: ASCON_W];
    assign a_arr[i]  = bus.req_a[ASCON_W*i +: ASCON_W];
    assign p_arr[i]  = bus.req_p[ASCON_W*i +: ASCON_W];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx),
    .gnt_vld    (gnt_vld)
  );

  // Grant only offered while idle; held low in reset so every output reads 0
  assign accept        = (state == S_IDLE) && gnt_vld;
  assign bus.req_ready = (RST && state == S_IDLE) ? gnt : '0;
  assign timeout_hit   = (wdog == TW'(TIMEOUT_CYC - 1));

  // Abort pulse lands on the terminal WAIT cycle; a same-cycle done suppresses it
  assign core_reset    = (state == S_WAIT) && !core_done && timeout_hit;
  assign core_start    = core_start_q;
  assign busy          = (state != S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_c     = rsp_c_q;
  assign bus.rsp_t     = rsp_t_q;
  assign bus.rsp_err   = rsp_err_q;

  // Job FSM: latch operands, kick the core, watch for done or timeout, hold the response
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= S_IDLE;
      last_grant   <= IDW'(NUM_REQ - 1);
      wdog         <= '0;
      core_sk      <= '0;
      core_n       <= '0;
      core_a       <= '0;
      core_p       <= '0;
      rsp_id_q     <= '0;
      rsp_c_q      <= '0;
      rsp_t_q      <= '0;
      rsp_err_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      core_start_q <= 1'b0;
    end else begin
      core_start_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            core_sk      <= sk_arr[gnt_idx];
            core_n       <= n_arr[gnt_idx];
            core_a       <= a_arr[gnt_idx];
            core_p       <= p_arr[gnt_idx];
            rsp_id_q     <= gnt_idx;
            last_grant   <= gnt_idx;
            core_start_q <= 1'b1;
            state        <= S_START;
          end
        end
        S_START: begin
          wdog  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          wdog <= wdog + TW'(1);
          if (core_done) begin
            rsp_c_q     <= core_c;
            rsp_t_q     <= core_t;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state       <= S_RESP;
          end else if (timeout_hit) begin
            rsp_c_q     <= '0;
            rsp_t_q     <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state       <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
